// File: rtl/hazard_scoreboard.sv
// Issue-stage hazard scoreboard: a DEPTH-deep shift register of in-flight writers
// that decides stall and operand forwarding. Define SCOREBOARD_FWD_EN to enable forwarding.
module hazard_scoreboard #(
  parameter int DEPTH = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hold,
  input  logic       issue_valid,
  input  logic [6:0] issue_rt,
  input  logic [6:0] issue_ra,
  input  logic [6:0] issue_rb,
  input  logic [6:0] issue_rc,
  input  logic       issue_we,
  input  logic       issue_use_a,
  input  logic       issue_use_b,
  input  logic       issue_use_c,
  input  logic [2:0] issue_lat,
  output logic       stall,
  output logic [2:0] fwd_sel_a,
  output logic [2:0] fwd_sel_b,
  output logic [2:0] fwd_sel_c,
  output logic       wb_valid,
  output logic [6:0] wb_rt
);

`ifdef SCOREBOARD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic       slot_valid_reg [DEPTH];
  logic [6:0] slot_rt_reg    [DEPTH];
  logic [2:0] slot_lat_reg   [DEPTH];

  logic [2:0] lat_clamped;
  logic [6:0] src_reg   [3];
  logic       src_use   [3];
  logic [2:0] src_sel   [3];
  logic       src_block [3];

  always_comb begin
    lat_clamped = issue_lat;
    if (issue_lat == 3'd0)
      lat_clamped = 3'd1;
    else if (int'(issue_lat) > DEPTH)
      lat_clamped = 3'(DEPTH);
  end

  assign src_reg[0] = issue_ra;
  assign src_reg[1] = issue_rb;
  assign src_reg[2] = issue_rc;
  assign src_use[0] = issue_use_a;
  assign src_use[1] = issue_use_b;
  assign src_use[2] = issue_use_c;

  // Each source scans from the youngest slot; the first hit decides, older hits are masked.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_src
      always_comb begin
        logic found;
        found         = 1'b0;
        src_sel[gi]   = 3'd0;
        src_block[gi] = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
          if (!found && src_use[gi] && slot_valid_reg[i] && slot_rt_reg[i] == src_reg[gi]) begin
            found = 1'b1;
            if (FWD_EN && (3'(i + 1) >= slot_lat_reg[i]))
              src_sel[gi] = 3'(i + 1);
            else
              src_block[gi] = 1'b1;
          end
        end
      end
    end
  endgenerate

  assign stall     = hold | (issue_valid & (src_block[0] | src_block[1] | src_block[2]));
  assign fwd_sel_a = src_sel[0];
  assign fwd_sel_b = src_sel[1];
  assign fwd_sel_c = src_sel[2];

  // A reset edge discards the writeback stage, so it is not reported in that cycle either.
  assign wb_valid  = slot_valid_reg[DEPTH-1] & ~hold & ~reset;
  assign wb_rt     = slot_rt_reg[DEPTH-1];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (reset) begin
          slot_valid_reg[gi] <= 1'b0;
          slot_rt_reg[gi]    <= 7'd0;
          slot_lat_reg[gi]   <= 3'd0;
        end else if (!hold) begin
          if (gi == 0) begin
            slot_valid_reg[gi] <= issue_valid & issue_we & ~stall;
            slot_rt_reg[gi]    <= issue_rt;
            slot_lat_reg[gi]   <= lat_clamped;
          end else begin
            slot_valid_reg[gi] <= slot_valid_reg[gi-1];
            slot_rt_reg[gi]    <= slot_rt_reg[gi-1];
            slot_lat_reg[gi]   <= slot_lat_reg[gi-1];
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized scoreboard bench for hazard_scoreboard: a list-of-producers model predicts
// stall, forwarding selects and writebacks; a negedge monitor pops and compares.
module tb_hazard_scoreboard;
  localparam int DEPTH  = 5;
  localparam int NCYC   = 4000;
`ifdef SCOREBOARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, hold, issue_valid, issue_we;
  logic       issue_use_a, issue_use_b, issue_use_c;
  logic [6:0] issue_rt, issue_ra, issue_rb, issue_rc;
  logic [2:0] issue_lat;
  logic       stall, wb_valid;
  logic [2:0] fwd_sel_a, fwd_sel_b, fwd_sel_c;
  logic [6:0] wb_rt;

  hazard_scoreboard #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .hold(hold), .issue_valid(issue_valid),
    .issue_rt(issue_rt), .issue_ra(issue_ra), .issue_rb(issue_rb), .issue_rc(issue_rc),
    .issue_we(issue_we), .issue_use_a(issue_use_a), .issue_use_b(issue_use_b),
    .issue_use_c(issue_use_c), .issue_lat(issue_lat), .stall(stall),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .fwd_sel_c(fwd_sel_c),
    .wb_valid(wb_valid), .wb_rt(wb_rt)
  );

  always #5 clk = ~clk;

  typedef struct { int rt; int lat; int age; } ent_t;
  typedef struct {
    logic stall; logic [2:0] sa, sb, sc; logic wbv; logic [6:0] wbrt; logic chk_rt;
  } exp_t;

  ent_t fl[$];
  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  function automatic int clamp_lat(input int l);
    if (l == 0) return 1;
    if (l > DEPTH) return DEPTH;
    return l;
  endfunction

  // Youngest in-flight producer of r decides; it is usable only once its age reaches its latency.
  function automatic void resolve(input logic use_f, input logic [6:0] r,
                                  output logic blk, output logic [2:0] sel);
    int best;
    best = -1;
    blk  = 1'b0;
    sel  = 3'd0;
    if (use_f)
      foreach (fl[k])
        if (fl[k].rt == int'(r) && (best < 0 || fl[k].age < fl[best].age)) best = k;
    if (best >= 0) begin
      if (FWD && fl[best].age >= fl[best].lat) sel = 3'(fl[best].age);
      else blk = 1'b1;
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("stall", int'(stall), int'(e.stall));
      if (!e.stall) begin
        chk("fwd_sel_a", int'(fwd_sel_a), int'(e.sa));
        chk("fwd_sel_b", int'(fwd_sel_b), int'(e.sb));
        chk("fwd_sel_c", int'(fwd_sel_c), int'(e.sc));
      end
      chk("wb_valid", int'(wb_valid), int'(e.wbv));
      if (e.wbv || e.chk_rt) chk("wb_rt", int'(wb_rt), int'(e.wbrt));
    end
  end

  initial begin
    logic p_reset, p_hold, p_valid, p_we, p_stall, post_rst;
    logic [6:0] p_rt;
    logic [2:0] p_lat;
    logic ba, bb, bc;
    exp_t e;

    reset = 1'b1; hold = 1'b0; issue_valid = 1'b0; issue_we = 1'b0;
    issue_use_a = 1'b0; issue_use_b = 1'b0; issue_use_c = 1'b0;
    issue_rt = '0; issue_ra = '0; issue_rb = '0; issue_rc = '0; issue_lat = '0;
    @(posedge clk);
    fl.delete();
    post_rst = 1'b1;
    p_stall = 1'b0; p_valid = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      #1;
      reset = (cyc < 2) || ($urandom_range(0, 149) == 0);
      hold  = (cyc >= 2) && ($urandom_range(0, 9) == 0);
      // A stalled instruction is re-presented unchanged.
      if (!(p_stall && p_valid && !p_reset && cyc > 0)) begin
        issue_valid = ($urandom_range(0, 9) < 7);
        issue_we    = ($urandom_range(0, 9) < 8);
        issue_rt    = 7'($urandom_range(0, 5));
        issue_ra    = 7'($urandom_range(0, 5));
        issue_rb    = ($urandom_range(0, 3) == 0) ? issue_ra : 7'($urandom_range(0, 5));
        issue_rc    = ($urandom_range(0, 3) == 0) ? issue_rt : 7'($urandom_range(0, 5));
        issue_use_a = ($urandom_range(0, 9) < 7);
        issue_use_b = ($urandom_range(0, 9) < 7);
        issue_use_c = ($urandom_range(0, 9) < 5);
        issue_lat   = 3'($urandom_range(0, 7));
      end

      resolve(issue_use_a, issue_ra, ba, e.sa);
      resolve(issue_use_b, issue_rb, bb, e.sb);
      resolve(issue_use_c, issue_rc, bc, e.sc);
      e.stall  = hold | (issue_valid & (ba | bb | bc));
      e.wbv    = 1'b0;
      e.wbrt   = 7'd0;
      e.chk_rt = post_rst;
      if (!hold && !reset)
        foreach (fl[k])
          if (fl[k].age == DEPTH) begin
            e.wbv  = 1'b1;
            e.wbrt = 7'(fl[k].rt);
          end
      q.push_back(e);

      p_reset = reset; p_hold = hold; p_valid = issue_valid; p_we = issue_we;
      p_stall = e.stall; p_rt = issue_rt; p_lat = issue_lat;

      @(posedge clk);
      if (p_reset) begin
        fl.delete();
        post_rst = 1'b1;
      end else if (!p_hold) begin
        ent_t n;
        post_rst = 1'b0;
        foreach (fl[k]) fl[k].age++;
        while (fl.size() > 0 && fl[0].age > DEPTH) void'(fl.pop_front());
        if (p_valid && p_we && !p_stall) begin
          n.rt = int'(p_rt); n.lat = clamp_lat(int'(p_lat)); n.age = 1;
          fl.push_back(n);
        end
      end
    end

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter DEPTH, default 7, SHALL set the number of in-flight execute slots, legal range 2..7.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; every state element SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit, SHALL be the synchronous, active-high reset.
REQ-004 Port hold, input, 1 bit, SHALL freeze all slots for the cycle.
REQ-005 Port issue_valid, input, 1 bit, SHALL flag a decoded instruction presented for issue.
REQ-006 Ports issue_rt, issue_ra, issue_rb and issue_rc, inputs, 7 bits each, SHALL carry the destination and source register numbers.
REQ-007 Ports issue_we, issue_use_a, issue_use_b and issue_use_c, inputs, 1 bit each, SHALL carry the write enable and the source-used flags.
REQ-008 Port issue_lat, input, 3 bits, SHALL carry the result latency in cycles.
REQ-009 Port stall, output, 1 bit, SHALL signal that the issue is refused this cycle.
REQ-010 Ports fwd_sel_a, fwd_sel_b and fwd_sel_c, outputs, 3 bits each, SHALL select the operand source: 0 = register file, k = slot of age k.
REQ-011 Port wb_valid, output, 1 bit, SHALL flag a writeback this cycle.
REQ-012 Port wb_rt, output, 7 bits, SHALL carry the register number being written back.

Function
REQ-013 Slot[i] SHALL hold {valid, rt, lat} of the instruction issued i+1 cycles earlier (age i+1); slot[DEPTH-1] SHALL be the writeback stage.
REQ-014 When hold=0, each clk edge SHALL shift slot[i] into slot[i+1], drop slot[DEPTH-1], and load slot[0] with the issuing instruction (valid = issue_valid & issue_we & ~stall), otherwise with a bubble (valid=0).
REQ-015 When hold=1, slots SHALL keep their values, stall SHALL be 1, and wb_valid SHALL be 0.
REQ-016 Effective latency SHALL be clamped: 0 becomes 1, and any value above DEPTH becomes DEPTH.
REQ-017 A source SHALL match slot[i] when its use flag is 1, slot[i].valid=1 and slot[i].rt equals the source register number.
REQ-018 Only the youngest (lowest-age) matching slot SHALL be considered; older matches SHALL be ignored.
REQ-019 A matched slot SHALL be ready when age >= lat.
REQ-020 stall SHALL be 1 when issue_valid=1 and any used source has a youngest match that is not ready.
REQ-021 stall, fwd_sel_a, fwd_sel_b and fwd_sel_c SHALL be combinational from the current inputs and slot state, with zero cycles of latency.
REQ-022 fwd_sel_x SHALL equal the age of the youngest ready match, or 0 when there is no match or the source is unused; its value while stall=1 is don't-care.
REQ-023 wb_valid SHALL equal slot[DEPTH-1].valid & ~hold, and wb_rt SHALL equal slot[DEPTH-1].rt.
REQ-024 An instruction whose destination equals one of its own sources SHALL be checked only against older slots.
REQ-025 Sources a, b and c SHALL be resolved independently, so that two sources naming the same register receive the same select.
REQ-026 While stall=1, a bubble SHALL enter slot[0] and the decoder SHALL re-present the same instruction.

Reset
REQ-027 When reset=1 at a clk edge, all slot valid bits SHALL clear and all rt and lat fields SHALL be set to 0, overriding hold and issue.
REQ-028 After reset, stall SHALL be 0, fwd_sel_a, fwd_sel_b and fwd_sel_c SHALL be 0, wb_valid SHALL be 0 and wb_rt SHALL be 0.
REQ-029 A reset asserted mid-operation SHALL discard every in-flight entry without producing any writeback.

Configuration
REQ-030 With macro SCOREBOARD_FWD_EN defined, forwarding SHALL operate as described in REQ-019 and REQ-022.
REQ-031 Without SCOREBOARD_FWD_EN, every match SHALL be treated as not ready, fwd_sel_a, fwd_sel_b and fwd_sel_c SHALL be constant 0, and the issue SHALL stall until the producer has left slot[DEPTH-1].

Verification
REQ-032 Scenario (FWD_EN): issue rt=5, lat=2, then next cycle ra=5 -> stall=1 for 1 cycle, then fwd_sel_a=2; wb_valid with wb_rt=5 appears 7 cycles after the first issue.
REQ-033 Scenario (FWD_EN): issue rt=9, lat=2 then rt=9, lat=6, then a consumer with rb=9 -> stall until the youngest producer reaches age 6; the older ready producer is ignored.
REQ-034 Scenario (no FWD_EN): issue rt=3, lat=1, then a consumer with ra=3 -> stall=1 for 7 cycles, then issue with fwd_sel_a=0.
REQ-035 Scenario: hold=1 for 3 cycles with 2 producers in flight -> slots frozen, wb_valid=0, and writebacks are delayed exactly 3 cycles.
REQ-036 Scenario: reset pulsed while 4 producers are in flight -> no wb_valid afterwards, and a consumer of those registers issues with no stall and fwd_sel=0.
REQ-037 Scenario: issue_lat=0 and issue_lat=7 with DEPTH=4 -> treated as 1 and 4 respectively; ra=rb=rc=rt of a single producer -> all three selects are equal.
